// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants and saturating helper for the PS/2 mouse front end
package ps2_pkg;

    // Frame and packet geometry
    localparam int FRAME_LEN  = 11;
    localparam int DATA_BITS  = 8;
    localparam int PACKET_LEN = 3;

    // Bit positions inside the packet status byte
    localparam int BTN_L   = 0;
    localparam int BTN_R   = 1;
    localparam int BTN_M   = 2;
    localparam int ALWAYS1 = 3;
    localparam int XSIGN   = 4;
    localparam int YSIGN   = 5;
    localparam int XOVF    = 6;
    localparam int YOVF    = 7;

    // Add a 9-bit two's complement delta to an 8-bit position, clamping to 0..255.
    // An overflowed delta is discarded rather than applied.
    function automatic logic [7:0] sat_add(input logic [7:0] pos,
                                           input logic [8:0] delta,
                                           input logic       ovf);
        logic signed [9:0] d;
        logic signed [9:0] sum;
        if (ovf) begin
            d = 10'sd0;
        end else begin
            d = $signed({delta[8], delta});
        end
        sum = $signed({2'b00, pos}) + d;
        if (sum < 10'sd0) begin
            return 8'd0;
        end else if (sum > 10'sd255) begin
            return 8'hFF;
        end else begin
            return sum[7:0];
        end
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// rtl/ps2_rx_frame.sv - PS/2 device-to-host frame receiver with synchroniser and timeout
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]  LAST_BIT     = 3'(DATA_BITS - 1);

    logic       clk_s1, clk_s2, clk_s3;
    logic       dat_s1, dat_s2;
    logic [1:0] state;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic       parity_bit;
    logic [15:0] idle_cnt;

    logic fall;
    logic timeout;
    logic parity_ok;
    logic stop_edge;

    // Bring the bus lines into the clock domain; reset to the idle-high bus level
    always_ff @(posedge clock) begin
        if (!reset) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            clk_s3 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            clk_s3 <= clk_s2;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    assign fall      = !clk_s2 && clk_s3;
    // An edge in the same cycle always beats the timeout
    assign timeout   = (state != IDLE) && !fall && (idle_cnt >= TIMEOUT_LAST);
    assign parity_ok = ^{shift, parity_bit};
    assign stop_edge = (state == STOP) && fall;

    // Byte results are combinational so the top level can register them on the stop edge itself
    assign rx_byte    = shift;
    assign byte_valid = stop_edge && dat_s2 && parity_ok;
    assign frame_err  = (stop_edge && !(dat_s2 && parity_ok)) || timeout;

    // Frame FSM plus the inter-edge watchdog
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            shift      <= 8'd0;
            parity_bit <= 1'b0;
            idle_cnt   <= 16'd0;
        end else begin
            if (fall || state == IDLE) begin
                idle_cnt <= 16'd0;
            end else if (!timeout) begin
                idle_cnt <= idle_cnt + 16'd1;
            end

            if (fall) begin
                case (state)
                    IDLE: begin
                        // A high level at an edge is line noise, not a start bit
                        if (!dat_s2) begin
                            state   <= DATA;
                            bit_cnt <= 3'd0;
                            shift   <= 8'd0;
                        end
                    end
                    DATA: begin
                        shift   <= {dat_s2, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == LAST_BIT) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        parity_bit <= dat_s2;
                        state      <= STOP;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end else if (timeout) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: rtl/ps2_mouse_position.sv
// rtl/ps2_mouse_position.sv - PS/2 mouse packet assembler with saturating X/Y position registers
module ps2_mouse_position
    import ps2_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter logic [7:0] X_INIT         = 8'd128,
    parameter logic [7:0] Y_INIT         = 8'd128
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] XPosition,
    output logic [7:0] YPosition,
    output logic [2:0] buttons,
    output logic       packet_valid,
    output logic       frame_error
);

    localparam logic [1:0] B0 = 2'd0;
    localparam logic [1:0] B1 = 2'd1;
    localparam logic [1:0] B2 = 2'd2;

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       frame_err;
    logic [1:0] pkt_state;
    logic [7:0] status;
    logic [7:0] dx_lo;
    logic       sync_err;

    ps2_rx_frame #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clock     (clock),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .frame_err (frame_err)
    );

    // A first byte without the always-one marker means we are out of step with the device
    assign sync_err = byte_valid && (pkt_state == B0) && !rx_byte[ALWAYS1];

    // Packet FSM and position accumulators
    always_ff @(posedge clock) begin
        if (!reset) begin
            pkt_state    <= B0;
            status       <= 8'd0;
            dx_lo        <= 8'd0;
            XPosition    <= X_INIT;
            YPosition    <= Y_INIT;
            buttons      <= 3'd0;
            packet_valid <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            packet_valid <= 1'b0;
            frame_error  <= frame_err || sync_err;

            if (frame_err) begin
                pkt_state <= B0;
            end else if (byte_valid) begin
                case (pkt_state)
                    B0: begin
                        if (rx_byte[ALWAYS1]) begin
                            status    <= rx_byte;
                            pkt_state <= B1;
                        end
                    end
                    B1: begin
                        dx_lo     <= rx_byte;
                        pkt_state <= B2;
                    end
                    B2: begin
                        XPosition    <= sat_add(XPosition, {status[XSIGN], dx_lo}, status[XOVF]);
                        YPosition    <= sat_add(YPosition, {status[YSIGN], rx_byte}, status[YOVF]);
                        buttons      <= status[BTN_M:BTN_L];
                        packet_valid <= 1'b1;
                        pkt_state    <= B0;
                    end
                    default: begin
                        pkt_state <= B0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_position.sv
// tb/tb_ps2_mouse_position.sv - scoreboard testbench for ps2_mouse_position
module tb_ps2_mouse_position;

    localparam int TO   = 300;
    localparam int HALF = 10;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] XPosition;
    logic [7:0] YPosition;
    logic [2:0] buttons;
    logic       packet_valid;
    logic       frame_error;

    ps2_mouse_position #(
        .TIMEOUT_CYCLES(TO),
        .X_INIT        (8'd128),
        .Y_INIT        (8'd128)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .XPosition   (XPosition),
        .YPosition   (YPosition),
        .buttons     (buttons),
        .packet_valid(packet_valid),
        .frame_error (frame_error)
    );

    always #10 clock = ~clock;

    typedef struct {
        bit         is_err;
        logic [7:0] x;
        logic [7:0] y;
        logic [2:0] btn;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mq[$];
    int         tests = 0;
    int         fails = 0;
    int         mx = 128;
    int         my = 128;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clock);
    endtask

    function automatic int clamp_add(input int pos, input logic [8:0] delta, input bit ovf);
        int d;
        int s;
        d = 0;
        if (!ovf) d = delta[8] ? int'(delta) - 512 : int'(delta);
        s = pos + d;
        if (s < 0) s = 0;
        if (s > 255) s = 255;
        return s;
    endfunction

    // Reference: collect bytes of a packet; bad first byte or any bus error restarts collection
    task automatic model_byte(input logic [7:0] b);
        exp_t e;
        mq.push_back(b);
        if (mq.size() == 1 && !b[3]) begin
            mq.delete();
            e.is_err = 1; e.x = 0; e.y = 0; e.btn = 0;
            sb.push_back(e);
        end else if (mq.size() == 3) begin
            mx = clamp_add(mx, {mq[0][4], mq[1]}, mq[0][6]);
            my = clamp_add(my, {mq[0][5], mq[2]}, mq[0][7]);
            e.is_err = 0; e.x = 8'(mx); e.y = 8'(my); e.btn = mq[0][2:0];
            sb.push_back(e);
            mq.delete();
        end
    endtask

    task automatic model_err();
        exp_t e;
        mq.delete();
        e.is_err = 1; e.x = 0; e.y = 0; e.btn = 0;
        sb.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            ps2_data = f[i];
            wait_cyc(HALF);
            ps2_clk = 1'b0;
            wait_cyc(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        wait_cyc(3 * HALF);
    endtask

    task automatic good_byte(input logic [7:0] b);
        model_byte(b);
        send_frame(b, 1'b0, 1'b0);
    endtask

    task automatic good_pkt(input logic [7:0] s, input logic [7:0] dx, input logic [7:0] dy);
        good_byte(s);
        good_byte(dx);
        good_byte(dy);
    endtask

    // Monitor: every output pulse must match the oldest pending expectation
    always @(negedge clock) begin
        exp_t e;
        if (reset && (packet_valid || frame_error)) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pulse: got pv=%0b fe=%0b expected none", packet_valid, frame_error);
            end else begin
                e = sb.pop_front();
                check("pulse_kind", {30'd0, packet_valid, frame_error}, e.is_err ? 32'd1 : 32'd2);
                if (!e.is_err) begin
                    check("pkt_x", XPosition, e.x);
                    check("pkt_y", YPosition, e.y);
                    check("pkt_btn", buttons, e.btn);
                end
            end
        end
    end

    initial begin
        logic [7:0] s;
        reset = 1'b0;
        wait_cyc(5);
        @(negedge clock);
        check("rst_x", XPosition, 128);
        check("rst_y", YPosition, 128);
        check("rst_btn", buttons, 0);
        check("rst_pv", packet_valid, 0);
        check("rst_fe", frame_error, 0);
        reset = 1'b1;

        // Idle bus: no pulses allowed, position untouched
        wait_cyc(10 * TO);
        @(negedge clock);
        check("idle_x", XPosition, 128);
        check("idle_y", YPosition, 128);

        // Basic packet, left button, dx=+5, dy=-3
        good_pkt(8'h29, 8'h05, 8'hFD);
        check("t2_x", XPosition, 133);
        check("t2_y", YPosition, 125);
        check("t2_btn", buttons, 3'b001);

        // Saturation at both ends
        good_pkt(8'h08, 8'h75, 8'h00);
        check("t3_x250", XPosition, 250);
        good_pkt(8'h08, 8'h14, 8'h00);
        check("t3_hi", XPosition, 255);
        good_pkt(8'h18, 8'h04, 8'h00);
        check("t3_x3", XPosition, 3);
        good_pkt(8'h18, 8'hF0, 8'h00);
        check("t3_lo", XPosition, 0);

        // Bad parity on the first byte, then a clean packet
        model_err();
        send_frame(8'h08, 1'b1, 1'b0);
        check("t4_x", XPosition, 0);
        good_pkt(8'h08, 8'h10, 8'h08);
        check("t4_x2", XPosition, 16);
        check("t4_y", YPosition, 133);

        // Out-of-sync first byte, then a clean packet
        good_byte(8'h00);
        good_pkt(8'h0A, 8'h01, 8'h01);
        check("t5_x", XPosition, 17);
        check("t5_btn", buttons, 3'b010);

        // Randomised packets with occasional bad-stop frames
        for (int n = 0; n < 24; n++) begin
            for (int k = 0; k < 3; k++) begin
                if ($urandom_range(0, 11) == 0) begin
                    model_err();
                    send_frame(8'($urandom), 1'b0, 1'b1);
                end
                if (k == 0) begin
                    s = 8'($urandom) | 8'h08;
                    if ($urandom_range(0, 3) != 0) s[7:6] = 2'b00;
                    good_byte(s);
                end else begin
                    good_byte(8'($urandom));
                end
            end
        end

        // Partial frame stalls after 5 data bits and must time out
        model_err();
        for (int i = 0; i < 6; i++) begin
            ps2_data = (i == 0) ? 1'b0 : 1'($urandom);
            wait_cyc(HALF);
            ps2_clk = 1'b0;
            wait_cyc(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        wait_cyc(TO + 50);

        // Reset in the middle of a packet discards it and restores the initial position
        good_byte(8'h08);
        reset = 1'b0;
        mq.delete();
        mx = 128;
        my = 128;
        wait_cyc(3);
        @(negedge clock);
        check("t6_rst_x", XPosition, 128);
        check("t6_rst_y", YPosition, 128);
        check("t6_rst_btn", buttons, 0);
        reset = 1'b1;
        wait_cyc(5);
        good_pkt(8'h0C, 8'h10, 8'h00);
        check("t6_x", XPosition, 144);
        check("t6_btn", buttons, 3'b100);

        wait_cyc(50);
        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
